// File: rtl/uart_rx_mmio_pkg.sv
// Shared IO map, register bit positions and receiver state type for the UART RX peripheral.
package uart_rx_mmio_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned ADDR_W = 32;

    localparam logic [ADDR_W-1:0] IO_BASE_ADDR           = 32'h4000_0000;
    localparam logic [ADDR_W-1:0] IO_UART_RX_OFFSET      = 32'h0000_0010;
    localparam logic [ADDR_W-1:0] IO_UART_RX_STAT_OFFSET = 32'h0000_0014;
    localparam logic [ADDR_W-1:0] IO_UART_RX_CTRL_OFFSET = 32'h0000_0018;

    localparam int unsigned IO_UART_RX_STAT_VALID_BIT = 0;
    localparam int unsigned IO_UART_RX_STAT_FULL_BIT  = 1;
    localparam int unsigned IO_UART_RX_STAT_OVR_BIT   = 2;
    localparam int unsigned IO_UART_RX_STAT_FERR_BIT  = 3;
    localparam int unsigned IO_UART_RX_STAT_BUSY_BIT  = 4;
    localparam int unsigned IO_UART_RX_STAT_CNT_LSB   = 8;
    localparam int unsigned IO_UART_RX_CTRL_IRQEN_BIT = 0;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx_mmio_core.sv
// 8N1 deserialiser: two-flop input synchroniser plus start/data/stop bit FSM.
module uart_rx_core
    import uart_rx_mmio_pkg::*;
#(
    parameter int unsigned UART_DIV = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    output logic       o_byte_valid,
    output logic [7:0] o_byte,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int unsigned CNT_W = $clog2(UART_DIV);

    logic             r_sync1, r_sync2, r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    rx_state_e        r_state;
    logic             w_rx;

    assign w_rx   = r_sync2;
    assign o_busy = (r_state != RX_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Start detection needs a true high->low edge, so a line held low after a bad stop bit is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= RX_IDLE;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            o_byte       <= '0;
            o_byte_valid <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_byte_valid <= 1'b0;
            o_frame_err  <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    if (r_prev && !w_rx) begin
                        r_cnt   <= CNT_W'(UART_DIV / 2 - 1);
                        r_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_cnt == '0) begin
                        if (!w_rx) begin
                            r_cnt   <= CNT_W'(UART_DIV - 1);
                            r_bit   <= '0;
                            r_state <= RX_DATA;
                        end else begin
                            r_state <= RX_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == '0) begin
                        r_shift <= {w_rx, r_shift[7:1]};
                        r_cnt   <= CNT_W'(UART_DIV - 1);
                        if (r_bit == 3'd7) r_state <= RX_STOP;
                        else               r_bit   <= r_bit + 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_cnt == '0) begin
                        if (w_rx) begin
                            o_byte       <= r_shift;
                            o_byte_valid <= 1'b1;
                        end else begin
                            o_frame_err  <= 1'b1;
                        end
                        r_state <= RX_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_mmio.sv
// MMIO UART receiver: byte FIFO, sticky error flags, interrupt enable and register decode.
module uart_rx_mmio
    import uart_rx_mmio_pkg::*;
#(
    parameter int unsigned       UART_DIV    = 868,
    parameter int unsigned       FIFO_DEPTH  = 4,
    parameter logic [ADDR_W-1:0] RX_DATA_OFF = IO_UART_RX_OFFSET,
    parameter logic [ADDR_W-1:0] RX_STAT_OFF = IO_UART_RX_STAT_OFFSET,
    parameter logic [ADDR_W-1:0] RX_CTRL_OFF = IO_UART_RX_CTRL_OFFSET
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mmio_req,
    input  logic              mmio_we,
    input  logic [ADDR_W-1:0] mmio_addr,
    input  logic [XLEN-1:0]   mmio_wdata,
    output logic [XLEN-1:0]   mmio_rdata,
    output logic              mmio_ready,
    input  logic              uart_rx,
    output logic              rx_irq
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic              w_byte_valid, w_frame_err, w_busy;
    logic [7:0]        w_byte;
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [PW-1:0]     r_wptr, r_rptr;
    logic [CW-1:0]     r_count;
    logic              r_ovr, r_ferr, r_irq_en;
    logic              w_empty, w_full, w_fire, w_pop, w_push, w_ovr_set, w_wr_stat;
    logic              w_sel_data, w_sel_stat, w_sel_ctrl;
    logic [ADDR_W-1:0] w_off;
    logic [XLEN-1:0]   w_rdata, w_stat;
    logic              w_unused;

    uart_rx_core #(.UART_DIV(UART_DIV)) u_core (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_rx         (uart_rx),
        .o_byte_valid (w_byte_valid),
        .o_byte       (w_byte),
        .o_frame_err  (w_frame_err),
        .o_busy       (w_busy)
    );

    assign w_off      = mmio_addr - IO_BASE_ADDR;
    assign w_sel_data = (w_off == RX_DATA_OFF);
    assign w_sel_stat = (w_off == RX_STAT_OFF);
    assign w_sel_ctrl = (w_off == RX_CTRL_OFF);
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_fire     = mmio_req & ~mmio_ready;
    assign w_pop      = w_fire & ~mmio_we & w_sel_data & ~w_empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign w_push     = w_byte_valid & (~w_full | w_pop);
    assign w_ovr_set  = w_byte_valid & w_full & ~w_pop;
    assign w_wr_stat  = w_fire & mmio_we & w_sel_stat;
    assign w_unused   = ^{mmio_wdata[XLEN-1:4], mmio_wdata[2:1]};

    always_comb begin
        w_stat = '0;
        w_stat[IO_UART_RX_STAT_VALID_BIT] = ~w_empty;
        w_stat[IO_UART_RX_STAT_FULL_BIT]  = w_full;
        w_stat[IO_UART_RX_STAT_OVR_BIT]   = r_ovr;
        w_stat[IO_UART_RX_STAT_FERR_BIT]  = r_ferr;
        w_stat[IO_UART_RX_STAT_BUSY_BIT]  = w_busy;
        w_stat[IO_UART_RX_STAT_CNT_LSB +: 4] = 4'(r_count);
        w_rdata = '0;
        if (!mmio_we) begin
            if (w_sel_data && !w_empty) w_rdata = XLEN'({1'b1, r_mem[r_rptr]});
            else if (w_sel_stat)        w_rdata = w_stat;
            else if (w_sel_ctrl)        w_rdata[IO_UART_RX_CTRL_IRQEN_BIT] = r_irq_en;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= w_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_ovr      <= 1'b0;
            r_ferr     <= 1'b0;
            r_irq_en   <= 1'b0;
            mmio_ready <= 1'b0;
            mmio_rdata <= '0;
            rx_irq     <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_ovr  <= w_ovr_set   | (r_ovr  & ~(w_wr_stat & mmio_wdata[IO_UART_RX_STAT_OVR_BIT]));
            r_ferr <= w_frame_err | (r_ferr & ~(w_wr_stat & mmio_wdata[IO_UART_RX_STAT_FERR_BIT]));
            if (w_fire && mmio_we && w_sel_ctrl) r_irq_en <= mmio_wdata[IO_UART_RX_CTRL_IRQEN_BIT];
            mmio_ready <= w_fire;
            if (w_fire) mmio_rdata <= w_rdata;
            rx_irq <= r_irq_en & (~w_empty | r_ovr | r_ferr);
        end
    end

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed and randomized checks of uart_rx_mmio against a queue-based model of the receive path.
module tb_uart_rx_mmio;
    import uart_rx_mmio_pkg::*;

    localparam int DIV   = 8;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              mmio_req = 1'b0;
    logic              mmio_we = 1'b0;
    logic [ADDR_W-1:0] mmio_addr = '0;
    logic [XLEN-1:0]   mmio_wdata = '0;
    logic [XLEN-1:0]   mmio_rdata;
    logic              mmio_ready;
    logic              uart_rx = 1'b1;
    logic              rx_irq;

    always #5 clk = ~clk;

    uart_rx_mmio #(.UART_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mmio_req   (mmio_req),
        .mmio_we    (mmio_we),
        .mmio_addr  (mmio_addr),
        .mmio_wdata (mmio_wdata),
        .mmio_rdata (mmio_rdata),
        .mmio_ready (mmio_ready),
        .uart_rx    (uart_rx),
        .rx_irq     (rx_irq)
    );

    logic [7:0] q[$];
    logic       m_ovr = 1'b0, m_ferr = 1'b0;
    int         n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Line-level frame driver; the model sees the byte as it is transmitted.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        @(negedge clk) uart_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rx = stop;
        repeat (DIV) @(negedge clk);
        uart_rx = 1'b1;
        if (!stop)                 m_ferr = 1'b1;
        else if (q.size() < DEPTH) q.push_back(d);
        else                       m_ovr = 1'b1;
    endtask

    task automatic mmio(input logic we, input logic [31:0] off, input logic [31:0] wd,
                        output logic [31:0] rd);
        logic got;
        got = 1'b0;
        rd  = '0;
        @(negedge clk);
        mmio_req = 1'b1; mmio_we = we; mmio_addr = IO_BASE_ADDR + off; mmio_wdata = wd;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (mmio_ready) begin got = 1'b1; rd = mmio_rdata; break; end
        end
        check("mmio_ready_seen", {31'b0, got}, 32'd1);
        @(negedge clk) mmio_req = 1'b0; mmio_we = 1'b0;
    endtask

    function automatic logic [31:0] model_stat();
        logic [31:0] s;
        s = 32'(q.size()) << 8;
        s[0] = (q.size() != 0);
        s[1] = (q.size() == DEPTH);
        s[2] = m_ovr;
        s[3] = m_ferr;
        return s;
    endfunction

    task automatic check_stat(input string tag);
        logic [31:0] rd;
        mmio(1'b0, IO_UART_RX_STAT_OFFSET, '0, rd);
        check(tag, rd, model_stat());
    endtask

    task automatic check_data(input string tag);
        logic [31:0] rd, exp;
        mmio(1'b0, IO_UART_RX_OFFSET, '0, rd);
        exp = (q.size() != 0) ? (32'h100 | 32'(q.pop_front())) : 32'h0;
        check(tag, rd, exp);
    endtask

    task automatic write_reg(input logic [31:0] off, input logic [31:0] wd);
        logic [31:0] rd;
        mmio(1'b1, off, wd, rd);
        if (off == IO_UART_RX_STAT_OFFSET) begin
            if (wd[2]) m_ovr  = 1'b0;
            if (wd[3]) m_ferr = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        seen;
        #1;
        check("reset_rdata", mmio_rdata, '0);
        check("reset_ready", {31'b0, mmio_ready}, '0);
        check("reset_irq",   {31'b0, rx_irq}, '0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        check_stat("stat_after_reset");

        send_frame(8'h55, 1'b1);
        repeat (4) @(negedge clk);
        check_stat("stat_one_byte");
        check_data("data_0x55");
        check_stat("stat_drained");

        send_frame(8'h01, 1'b1);
        send_frame(8'h80, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h00, 1'b1);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 5; i++) check_data($sformatf("data_b2b_%0d", i));

        for (int i = 0; i < 5; i++) send_frame(8'($urandom), 1'b1);
        repeat (4) @(negedge clk);
        check_stat("stat_overrun_full");
        for (int i = 0; i < 4; i++) check_data($sformatf("data_ovr_%0d", i));
        write_reg(IO_UART_RX_STAT_OFFSET, 32'h4);
        check_stat("stat_ovr_cleared");

        send_frame(8'hA5, 1'b0);
        repeat (4) @(negedge clk);
        check_stat("stat_frame_err");
        write_reg(IO_UART_RX_STAT_OFFSET, 32'h8);
        check_stat("stat_ferr_cleared");

        @(negedge clk) uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        check_stat("stat_after_glitch");

        write_reg(IO_UART_RX_CTRL_OFFSET, 32'h1);
        mmio(1'b0, IO_UART_RX_CTRL_OFFSET, '0, rd);
        check("ctrl_readback", rd, 32'h1);
        send_frame(8'h3C, 1'b1);
        seen = rx_irq;
        for (int i = 0; i < 3 && !seen; i++) begin
            @(posedge clk); #1;
            seen = rx_irq;
        end
        check("irq_raised", {31'b0, seen}, 32'd1);
        check_data("data_0x3C");
        @(posedge clk); #1;
        check("irq_cleared", {31'b0, rx_irq}, '0);
        write_reg(IO_UART_RX_CTRL_OFFSET, 32'h0);

        for (int r = 0; r < 3; r++) begin
            int n;
            n = int'($urandom_range(1, 5));
            for (int i = 0; i < n; i++) send_frame(8'($urandom), 1'b1);
            repeat (4) @(negedge clk);
            check_stat($sformatf("rand_stat_%0d", r));
            if (m_ovr) write_reg(IO_UART_RX_STAT_OFFSET, 32'h4);
            for (int i = 0, m = q.size(); i <= m; i++) check_data($sformatf("rand_data_%0d_%0d", r, i));
        end

        write_reg(IO_UART_RX_CTRL_OFFSET, 32'h1);
        send_frame(8'hC3, 1'b1);
        repeat (4) @(negedge clk);
        check("irq_before_reset", {31'b0, rx_irq}, 32'd1);
        @(negedge clk) uart_rx = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        mmio_req = 1'b1; mmio_we = 1'b0; mmio_addr = IO_BASE_ADDR + IO_UART_RX_STAT_OFFSET;
        #2 rst_n = 1'b0;
        #1;
        check("midreset_rdata", mmio_rdata, '0);
        check("midreset_ready", {31'b0, mmio_ready}, '0);
        check("midreset_irq",   {31'b0, rx_irq}, '0);
        @(posedge clk); #1;
        check("midreset_ready_held", {31'b0, mmio_ready}, '0);
        mmio_req = 1'b0;
        uart_rx  = 1'b1;
        q.delete();
        m_ovr = 1'b0; m_ferr = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        check_stat("stat_after_midreset");
        mmio(1'b0, IO_UART_RX_CTRL_OFFSET, '0, rd);
        check("ctrl_after_midreset", rd, '0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

    initial begin
        #5ms;
        n_checks++;
        n_fail++;
        $display("FAIL global_timeout: observed running expected finished");
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_rx_mmio.md
Name: uart_rx_mmio

Overview:
- MMIO-mapped UART receiver; the receive-side counterpart of the existing LED/UART-TX peripheral.
- Deserialises 8N1 frames from the `uart_rx` pin, buffers bytes in a small FIFO, and exposes data, status and control registers on the IO bus.
- Shares the same request/ready MMIO handshake and the same UART_DIV bit-timing convention as the TX side, so one divider value serves both directions.

Parameters:
- UART_DIV, 868, clocks per bit (≥4); same meaning as on the TX side.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, ≥2.
- RX_DATA_OFF, `IO_UART_RX_OFFSET, byte offset of RX_DATA from `IO_BASE_ADDR.
- RX_STAT_OFF, `IO_UART_RX_STAT_OFFSET, byte offset of RX_STAT.
- RX_CTRL_OFF, `IO_UART_RX_CTRL_OFFSET, byte offset of RX_CTRL.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- mmio_req  in  1  bus request; held until mmio_ready.
- mmio_we  in  1  1 = write, 0 = read.
- mmio_addr  in  `ADDR_W  full byte address.
- mmio_wdata  in  `XLEN  write data.
- mmio_rdata  out  `XLEN  read data; valid while mmio_ready=1.
- mmio_ready  out  1  one-cycle completion pulse.
- uart_rx  in  1  asynchronous serial input; idle high.
- rx_irq  out  1  level interrupt.

Behaviour:
- Reset and clocking (already decided): one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - mmio_rdata=0, mmio_ready=0, rx_irq=0.
  - FIFO empty; overrun=0, frame_err=0, irq_en=0.
  - Receiver in IDLE; synchroniser flops=1.
- Input synchronisation: uart_rx passes through a 2-flop synchroniser. All receiver logic uses the synchronised value (adds 2 cycles of latency).
- Receiver FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: on a synced high→low transition, load bit counter = UART_DIV/2 − 1 and go to START.
  - START: at counter expiry, sample. If still 0, reload UART_DIV−1 and go to DATA. If 1, treat as a glitch/false start and return to IDLE with no side effects.
  - DATA: sample every UART_DIV cycles, 8 bits, LSB first, shifted into the shift register. After bit 7, go to STOP.
  - STOP: sample after UART_DIV cycles.
    - Stop=1: push the byte.
    - Stop=0: discard the byte, set frame_err (sticky).
    - Either way return to IDLE. A line still low after a stop error is not treated as a start until it returns high.
- FIFO: FIFO_DEPTH×8, with count width clog2(FIFO_DEPTH)+1.
  - A push when full is dropped and sets overrun (sticky).
  - A push and a pop in the same cycle are both performed; if full, the push is accepted because the pop frees a slot. Count is unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- MMIO handshake:
  - req is sampled only when mmio_ready=0.
  - A sampled req produces mmio_ready=1 on the next edge, with mmio_rdata registered on that same edge.
  - mmio_ready is exactly one cycle, then 0 for at least one cycle, so one request is completed exactly once.
  - Decode uses mmio_addr − `IO_BASE_ADDR.
- Registers:
  - RX_DATA (read):
    - Not empty: rdata = {23'b0, 1'b1, byte} and the FIFO pops on the edge that asserts ready.
    - Empty: rdata = 0; no pop, no error.
    - Writes are ignored.
  - RX_STAT (read): bit0 not_empty, bit1 full, bit2 overrun, bit3 frame_err, bit4 busy (FSM≠IDLE), bits[11:8] count; all other bits 0.
  - RX_STAT (write): write-1-to-clear on bits 2 and 3. If a set event and a clear occur in the same cycle, set wins.
  - RX_CTRL: bit0 irq_en, read/write; other bits read 0.
  - Any other address: reads return 0, writes are ignored, ready is still returned.
- rx_irq = registered (irq_en & (not_empty | overrun | frame_err)).
- Reset mid-frame or mid-transaction: immediate return to reset state; partial byte lost; a pending ready is not issued.

Decomposition:
- Shared defines header gains:
  - `IO_UART_RX_OFFSET, `IO_UART_RX_STAT_OFFSET, `IO_UART_RX_CTRL_OFFSET.
  - Status bit indices: `IO_UART_RX_STAT_VALID_BIT, _FULL_BIT, _OVR_BIT, _FERR_BIT, _BUSY_BIT.
  - `IO_UART_RX_CTRL_IRQEN_BIT.
- One sub-module, uart_rx_core: synchroniser + FSM.
  - Outputs: byte_valid pulse, byte[7:0], frame_err pulse, busy.
  - FIFO and register decode stay in uart_rx_mmio.

Test Plan:
- Bench uses UART_DIV=8, FIFO_DEPTH=4.
- Send 0x55 as 8N1 (bit=8 clk) → RX_STAT bit0=1, count=1; RX_DATA reads 0x155; RX_STAT then bit0=0, count=0.
- Send 0x01,0x80,0xFF,0x00 back-to-back → RX_DATA returns 0x101,0x180,0x1FF,0x100 in order; a fifth read returns 0x0.
- Send 5 bytes with no reads → STAT full=1, overrun=1, count=4; first 4 bytes are intact. Write STAT 0x4 → overrun=0.
- Frame with stop bit=0 carrying 0xA5 → frame_err=1, count=0. Write STAT 0x8 → frame_err=0.
- 3-clk low glitch on uart_rx in IDLE → busy returns 0, count=0, no error flags.
- CTRL=1, send 0x3C → rx_irq=1 within 2 clk of the stop sample. Read RX_DATA → rx_irq=0 next cycle. Assert rst_n mid-frame → all outputs are at reset values immediately.
